// File: rtl/truth_table_monitor.sv
// Response monitor for exhaustive 3-input sweeps: samples f once per settled x/y/z vector.
// Optional first-failure capture ports are enabled by defining TTM_FIRST_FAIL_EN.
module truth_table_monitor #(
    parameter logic [7:0]  EXP_TABLE = 8'b0000_0000,
    parameter int unsigned SETTLE    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       x,
    input  logic       y,
    input  logic       z,
    input  logic       f,
    output logic [7:0] table_out,
    output logic [7:0] seen,
    output logic       sample,
    output logic       mismatch,
    output logic       conflict,
    output logic [3:0] err_count,
    output logic       done,
    output logic       pass
`ifdef TTM_FIRST_FAIL_EN
    ,
    output logic       first_fail_vld,
    output logic [2:0] first_fail_idx
`endif
);

    localparam logic [3:0] SETTLE_MAX = 4'(SETTLE);
    localparam logic [3:0] SAMPLE_AT  = 4'(SETTLE - 1);

    logic [2:0] vec;
    logic [2:0] vec_q;
    logic [3:0] stab_cnt;
    logic [3:0] stab_cnt_nxt;
    logic       stable;
    logic       fire;
    logic       f_bad;
    logic [7:0] table_nxt;
    logic [7:0] seen_nxt;
    logic       conflict_nxt;
    logic [3:0] err_nxt;

    assign vec    = {x, y, z};
    assign stable = (vec == vec_q);
    // Exactly one sample per stable period: the counter saturates past SAMPLE_AT.
    assign fire   = stable && (stab_cnt == SAMPLE_AT);
    assign f_bad  = (f != EXP_TABLE[vec]);

    always_comb begin
        stab_cnt_nxt = 4'd0;
        if (stable) begin
            if (stab_cnt >= SETTLE_MAX)
                stab_cnt_nxt = stab_cnt;
            else
                stab_cnt_nxt = stab_cnt + 4'd1;
        end
    end

    always_comb begin
        table_nxt    = table_out;
        seen_nxt     = seen;
        conflict_nxt = conflict;
        err_nxt      = err_count;
        if (fire) begin
            if (!seen[vec]) begin
                table_nxt[vec] = f;
                seen_nxt[vec]  = 1'b1;
            end else if (table_out[vec] != f) begin
                conflict_nxt = 1'b1;
            end
            if (f_bad && (err_count != 4'hF))
                err_nxt = err_count + 4'd1;
        end
    end

    // Synchronous clear mirrors reset and wins over a coincident sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q     <= 3'd0;
            stab_cnt  <= 4'd0;
            table_out <= 8'd0;
            seen      <= 8'd0;
            sample    <= 1'b0;
            mismatch  <= 1'b0;
            conflict  <= 1'b0;
            err_count <= 4'd0;
        end else if (clear) begin
            vec_q     <= 3'd0;
            stab_cnt  <= 4'd0;
            table_out <= 8'd0;
            seen      <= 8'd0;
            sample    <= 1'b0;
            mismatch  <= 1'b0;
            conflict  <= 1'b0;
            err_count <= 4'd0;
        end else begin
            vec_q     <= vec;
            stab_cnt  <= stab_cnt_nxt;
            table_out <= table_nxt;
            seen      <= seen_nxt;
            sample    <= fire;
            mismatch  <= fire && f_bad;
            conflict  <= conflict_nxt;
            err_count <= err_nxt;
        end
    end

    assign done = (seen == 8'hFF);
    assign pass = done && !conflict && (err_count == 4'd0);

`ifdef TTM_FIRST_FAIL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_vld <= 1'b0;
            first_fail_idx <= 3'd0;
        end else if (clear) begin
            first_fail_vld <= 1'b0;
            first_fail_idx <= 3'd0;
        end else if (fire && f_bad && !first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_idx <= vec;
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_monitor.sv
// Randomized and directed bench for truth_table_monitor, checked every cycle against a
// run-length behavioural model; also covers TTM_FIRST_FAIL_EN when that macro is defined.
module tb_truth_table_monitor;

    localparam logic [7:0] EXP    = 8'hE8;
    localparam int         SETTLE = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       clear = 1'b0;
    logic       x = 1'b0, y = 1'b0, z = 1'b0, f = 1'b0;
    logic [7:0] table_out;
    logic [7:0] seen;
    logic       sample;
    logic       mismatch;
    logic       conflict;
    logic [3:0] err_count;
    logic       done;
    logic       pass;
`ifdef TTM_FIRST_FAIL_EN
    logic       first_fail_vld;
    logic [2:0] first_fail_idx;
`endif

    truth_table_monitor #(.EXP_TABLE(EXP), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .x(x), .y(y), .z(z), .f(f),
        .table_out(table_out), .seen(seen), .sample(sample), .mismatch(mismatch),
        .conflict(conflict), .err_count(err_count), .done(done), .pass(pass)
`ifdef TTM_FIRST_FAIL_EN
        , .first_fail_vld(first_fail_vld), .first_fail_idx(first_fail_idx)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int sample_seen = 0;
    int mismatch_seen = 0;

    // Model: a vector is sampled on the edge where it completes SETTLE+1 consecutive
    // edges; reset/clear counts as one virtual edge of vector 000.
    bit [7:0] m_table, m_seen;
    bit       m_conflict, m_sample, m_mismatch, m_ffv;
    bit [2:0] m_ffi, last_vec;
    int       m_err, run;

    function automatic bit maj(input bit [2:0] v);
        return (int'(v[2]) + int'(v[1]) + int'(v[0])) >= 2;
    endfunction

    task automatic model_reset();
        m_table = 8'd0; m_seen = 8'd0; m_conflict = 1'b0; m_sample = 1'b0;
        m_mismatch = 1'b0; m_ffv = 1'b0; m_ffi = 3'd0; m_err = 0;
        last_vec = 3'd0; run = 1;
    endtask

    task automatic model_step();
        bit [2:0] v;
        v = {x, y, z};
        if (clear) begin
            model_reset();
            return;
        end
        if (v == last_vec) begin
            if (run < 1000) run++;
        end else begin
            run = 1;
            last_vec = v;
        end
        m_sample   = (run == SETTLE + 1);
        m_mismatch = 1'b0;
        if (m_sample) begin
            if (!m_seen[v]) begin
                m_table[v] = f;
                m_seen[v]  = 1'b1;
            end else if (m_table[v] != f) begin
                m_conflict = 1'b1;
            end
            if (f != EXP[v]) begin
                m_mismatch = 1'b1;
                if (m_err < 15) m_err++;
                if (!m_ffv) begin
                    m_ffv = 1'b1;
                    m_ffi = v;
                end
            end
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_output();
        check_val("table_out", int'(table_out), int'(m_table));
        check_val("seen", int'(seen), int'(m_seen));
        check_val("sample", int'(sample), int'(m_sample));
        check_val("mismatch", int'(mismatch), int'(m_mismatch));
        check_val("conflict", int'(conflict), int'(m_conflict));
        check_val("err_count", int'(err_count), m_err);
        check_val("done", int'(done), int'(m_seen == 8'hFF));
        check_val("pass", int'(pass), int'((m_seen == 8'hFF) && !m_conflict && (m_err == 0)));
`ifdef TTM_FIRST_FAIL_EN
        check_val("first_fail_vld", int'(first_fail_vld), int'(m_ffv));
        check_val("first_fail_idx", int'(first_fail_idx), int'(m_ffi));
`endif
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (rst_n) model_step();
        #1;
        check_output();
        if (sample === 1'b1) sample_seen++;
        if (mismatch === 1'b1) mismatch_seen++;
    end

    task automatic apply_stimulus(input bit [2:0] v, input bit fv, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            {x, y, z} = v;
            f = fv;
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic sweep(input bit [7:0] bad, input int last_idx);
        for (int i = 0; i <= last_idx; i++)
            apply_stimulus(3'(i), maj(3'(i)) ^ bad[i], 6);
    endtask

    task automatic settle_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int base_s, base_m;
        bit [2:0] v;
        bit fv;
        int n;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Full correct majority sweep
        base_s = sample_seen;
        sweep(8'h00, 7);
        settle_edge();
        check_val("sweep_samples", sample_seen - base_s, 8);
        check_val("sweep_table", int'(table_out), 'hE8);
        check_val("sweep_seen", int'(seen), 'hFF);
        check_val("sweep_done", int'(done), 1);
        check_val("sweep_pass", int'(pass), 1);
        check_val("sweep_err", int'(err_count), 0);

        // Vectors held too briefly are never sampled
        do_clear();
        base_s = sample_seen;
        apply_stimulus(3'b011, 1'b1, 3);
        apply_stimulus(3'b100, 1'b0, 3);
        settle_edge();
        check_val("short_seen", int'(seen), 0);
        check_val("short_samples", sample_seen - base_s, 0);

        // Wrong f (0) at index 5
        do_clear();
        base_m = mismatch_seen;
        sweep(8'h20, 7);
        settle_edge();
        check_val("mm_pulses", mismatch_seen - base_m, 1);
        check_val("mm_err", int'(err_count), 1);
        check_val("mm_done", int'(done), 1);
        check_val("mm_pass", int'(pass), 0);
        check_val("mm_table", int'(table_out), 'hC8);
`ifdef TTM_FIRST_FAIL_EN
        check_val("mm_ff_vld", int'(first_fail_vld), 1);
        check_val("mm_ff_idx", int'(first_fail_idx), 5);
`endif

        // Conflict: index 2 first 0 then 1
        do_clear();
        apply_stimulus(3'b010, 1'b0, 6);
        apply_stimulus(3'b000, 1'b0, 6);
        apply_stimulus(3'b010, 1'b1, 6);
        settle_edge();
        check_val("cf_conflict", int'(conflict), 1);
        check_val("cf_table2", int'(table_out[2]), 0);
        check_val("cf_err", int'(err_count), 1);
        apply_stimulus(3'b000, 1'b0, 8);
        settle_edge();
        check_val("cf_sticky", int'(conflict), 1);

        // 20 wrong samples alternating 000 and 111
        do_clear();
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(3'b000, 1'b1, 6);
            apply_stimulus(3'b111, 1'b0, 6);
            if (i == 4) begin
                settle_edge();
                check_val("sat_mid_err", int'(err_count), 10);
            end
        end
        settle_edge();
        check_val("sat_err", int'(err_count), 15);
        check_val("sat_seen", int'(seen), 'h81);
        check_val("sat_table", int'(table_out), 'h01);
        check_val("sat_conflict", int'(conflict), 0);

        // Clear coincident with the sample edge of 110
        apply_stimulus(3'b000, 1'b0, 3);
        apply_stimulus(3'b110, 1'b1, 4);
        @(negedge clk);
        clear = 1'b1;
        settle_edge();
        check_val("clr_sample", int'(sample), 0);
        check_val("clr_seen", int'(seen), 0);
        check_val("clr_err", int'(err_count), 0);
        check_val("clr_table", int'(table_out), 0);
        @(negedge clk);
        clear = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check_val("clr_wait_seen", int'(seen), 0);
        settle_edge();
        check_val("clr_resample", int'(sample), 1);
        check_val("clr_reseen", int'(seen), 'h40);
        check_val("clr_retable", int'(table_out), 'h40);

        // Asynchronous reset between edges mid-sweep
        do_clear();
        sweep(8'h00, 3);
        settle_edge();
        check_val("ar_pre_seen", int'(seen), 'h0F);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        {x, y, z} = 3'b000;
        f = 1'b0;
        #1;
        check_val("ar_table", int'(table_out), 0);
        check_val("ar_seen", int'(seen), 0);
        check_val("ar_sample", int'(sample), 0);
        check_val("ar_conflict", int'(conflict), 0);
        check_val("ar_err", int'(err_count), 0);
        check_val("ar_done", int'(done), 0);
        #1 rst_n = 1'b1;
        // Stable 000 after release is sampled on the 4th rising edge (edge index 3 from 0)
        for (int i = 1; i <= 4; i++) begin
            settle_edge();
            check_val("ar_latency", int'(sample), int'(i == 4));
        end
        check_val("ar_post_seen", int'(seen), 'h01);

        // Randomized holds, f errors and occasional clears
        for (int i = 0; i < 250; i++) begin
            v  = 3'($urandom_range(0, 7));
            n  = $urandom_range(1, 8);
            fv = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : maj(v);
            if ($urandom_range(0, 39) == 0) do_clear();
            apply_stimulus(v, fv, n);
        end
        settle_edge();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
